mmu_table_loader: RTL and testbench

Sequencer that owns the MMU mapping RAM while the 6809 is halted. It fills the whole 256-entry table with the default map after reset, and on command fills or copies one 8-entry task. It halts the CPU via nHALT, waits for halt acknowledge (BA=BS=1), takes the MMU RAM port with `OWN`, runs read/write cycles, then releases the CPU. It sits beside the MMU decoder; while `OWN`=1 the decoder tristates its MMU RAM drive.

---
 rtl/mmu_pkg.sv | 32 +++
 rtl/mmu_table_loader_if.sv | 30 +++
 rtl/mmu_table_loader_ack_sync.sv | 18 +
 rtl/mmu_table_loader.sv | 167 ++++++++++++++++
 tb/tb_mmu_table_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_pkg.sv
// Shared types and helpers for the MMU mapping-table loader.
package mmu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_RD_ADDR,
    S_RD_SAMPLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_NEXT,
    S_REL,
    S_FIN
  } state_t;

  localparam logic [1:0] MODE_FILL_ALL  = 2'b00;
  localparam logic [1:0] MODE_COPY      = 2'b01;
  localparam logic [1:0] MODE_FILL_TASK = 2'b10;
  localparam logic [1:0] MODE_NOP       = 2'b11;

  localparam logic [1:0] REGION_RAM  = 2'b10;
  localparam logic [1:0] REGION_ROM0 = 2'b00;
  localparam logic [1:0] REGION_ROM1 = 2'b01;
  localparam logic [1:0] REGION_EXT  = 2'b11;

  // Lower 32K of every task maps to RAM, upper 32K to ROM0, matching unmapped behaviour.
  function automatic logic [7:0] default_entry(input logic [2:0] idx);
    return {(idx[2] ? REGION_ROM0 : REGION_RAM), 3'b000, idx};
  endfunction

endpackage

// File: rtl/mmu_table_loader_if.sv
// Command, CPU-halt handshake and MMU RAM port of the table loader.
interface mmu_table_loader_if;
  logic       START;
  logic [1:0] CMD_MODE;
  logic [4:0] CMD_SRC;
  logic [4:0] CMD_DST;
  logic [7:0] FILL_VALUE;
  logic       BA;
  logic       BS;
  logic       nHALT;
  logic       OWN;
  logic [7:0] MMU_ADDR;
  logic [7:0] MMU_DOUT;
  logic       MMU_DOE;
  logic [7:0] MMU_DIN;
  logic       MMU_nRD;
  logic       MMU_nWR;
  logic       BUSY;
  logic       DONE;

  modport master (
    input  START, CMD_MODE, CMD_SRC, CMD_DST, FILL_VALUE, BA, BS, MMU_DIN,
    output nHALT, OWN, MMU_ADDR, MMU_DOUT, MMU_DOE, MMU_nRD, MMU_nWR, BUSY, DONE
  );

  modport slave (
    output START, CMD_MODE, CMD_SRC, CMD_DST, FILL_VALUE, BA, BS, MMU_DIN,
    input  nHALT, OWN, MMU_ADDR, MMU_DOUT, MMU_DOE, MMU_nRD, MMU_nWR, BUSY, DONE
  );
endinterface

// File: rtl/mmu_table_loader_ack_sync.sv
// Multi-stage synchroniser bringing the asynchronous halt acknowledge into the clock domain.
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];
endmodule

// File: rtl/mmu_table_loader.sv
// Halts the CPU, takes the MMU RAM port and fills or copies mapping entries.
// Entry cost is W+3 cycles for writes only, W+5 for copies; all outputs registered.
module mmu_table_loader
  import mmu_pkg::*;
#(
  parameter bit AUTOINIT    = 1'b1,
  parameter int WR_CYCLES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic                CLKX4,
  input logic                RESET,
  mmu_table_loader_if.master bus
);
  localparam logic [2:0] WR_LEN = 3'(WR_CYCLES);

  state_t     state;
  logic [1:0] mode_q;
  logic [4:0] src_q;
  logic [4:0] dst_q;
  logic [7:0] fill_q;
  logic [7:0] cnt;
  logic [2:0] wr_cnt;
  logic       ack;

  logic       nhalt, own, doe, nrd, nwr, busy, done;
  logic [7:0] addr, dout;

  logic [7:0] cnt_inc, ent_cnt, ent_rd_addr, ent_wr_addr, ent_wr_data;
  logic       last_entry, launch;

  ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (CLKX4),
    .rst (RESET),
    .d   (bus.BA & bus.BS),
    .q   (ack)
  );

  // Full fill walks all 256 addresses; task commands only walk the 3-bit index.
  always_comb begin
    if (mode_q == MODE_FILL_ALL) begin
      cnt_inc    = cnt + 8'd1;
      last_entry = (cnt == 8'hFF);
    end else begin
      cnt_inc    = {5'd0, cnt[2:0] + 3'd1};
      last_entry = (cnt[2:0] == 3'd7);
    end
    ent_cnt     = (state == S_NEXT) ? cnt_inc : cnt;
    ent_rd_addr = {src_q, ent_cnt[2:0]};
    ent_wr_addr = (mode_q == MODE_FILL_ALL) ? ent_cnt : {dst_q, ent_cnt[2:0]};
    case (mode_q)
      MODE_FILL_ALL:  ent_wr_data = default_entry(ent_cnt[2:0]);
      MODE_FILL_TASK: ent_wr_data = fill_q;
      default:        ent_wr_data = bus.MMU_DIN;
    endcase
  end

  // Ack is only consulted at entry boundaries so a started entry always completes.
  assign launch = ack && ((state == S_REQ) || (state == S_NEXT && !last_entry));

  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      state  <= AUTOINIT ? S_REQ : S_IDLE;
      mode_q <= MODE_FILL_ALL;
      src_q  <= '0;
      dst_q  <= '0;
      fill_q <= '0;
      cnt    <= '0;
      wr_cnt <= '0;
      nhalt  <= !AUTOINIT;
      busy   <= AUTOINIT;
      own    <= 1'b0;
      doe    <= 1'b0;
      nrd    <= 1'b1;
      nwr    <= 1'b1;
      addr   <= '0;
      dout   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            mode_q <= bus.CMD_MODE;
            src_q  <= bus.CMD_SRC;
            dst_q  <= bus.CMD_DST;
            fill_q <= bus.FILL_VALUE;
            cnt    <= '0;
            busy   <= 1'b1;
            if (bus.CMD_MODE == MODE_NOP) begin
              state <= S_FIN;
            end else begin
              nhalt <= 1'b0;
              state <= S_REQ;
            end
          end
        end
        S_REQ: if (ack) own <= 1'b1;
        S_RD_ADDR: state <= S_RD_SAMPLE;
        S_RD_SAMPLE: begin
          nrd   <= 1'b1;
          addr  <= ent_wr_addr;
          dout  <= ent_wr_data;
          doe   <= 1'b1;
          state <= S_WR_SETUP;
        end
        S_WR_SETUP: begin
          nwr    <= 1'b0;
          wr_cnt <= 3'd1;
          state  <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (wr_cnt == WR_LEN) begin
            nwr   <= 1'b1;
            state <= S_WR_HOLD;
          end else begin
            wr_cnt <= wr_cnt + 3'd1;
          end
        end
        S_WR_HOLD: begin
          doe   <= 1'b0;
          state <= S_NEXT;
        end
        S_NEXT: begin
          cnt <= cnt_inc;
          if (last_entry) begin
            own   <= 1'b0;
            nhalt <= 1'b1;
            state <= S_REL;
          end else if (!ack) begin
            own   <= 1'b0;
            state <= S_REQ;
          end
        end
        S_REL: if (!ack) state <= S_FIN;
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (launch) begin
        if (mode_q == MODE_COPY) begin
          state <= S_RD_ADDR;
          addr  <= ent_rd_addr;
          nrd   <= 1'b0;
        end else begin
          state <= S_WR_SETUP;
          addr  <= ent_wr_addr;
          dout  <= ent_wr_data;
          doe   <= 1'b1;
        end
      end
    end
  end

  assign bus.nHALT    = nhalt;
  assign bus.OWN      = own;
  assign bus.MMU_ADDR = addr;
  assign bus.MMU_DOUT = dout;
  assign bus.MMU_DOE  = doe;
  assign bus.MMU_nRD  = nrd;
  assign bus.MMU_nWR  = nwr;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
endmodule

// File: tb/tb_mmu_table_loader.sv
// Bench for mmu_table_loader: RAM model, CPU halt model and write scoreboard.
module tb_mmu_table_loader;
  import mmu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_table_loader_if bus();

  mmu_table_loader #(.AUTOINIT(1'b1), .WR_CYCLES(2), .SYNC_STAGES(2)) dut (
    .CLKX4 (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb_q[$];
  logic [7:0] mem [256];
  assign bus.MMU_DIN = mem[bus.MMU_ADDR];

  int checks = 0, errors = 0;
  int wr_count = 0, busy_cycles = 0, halt_cnt = 0, ack_delay = 0;
  bit cpu_auto = 1'b0, nhalt_low = 1'b0, prev_nwr = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock at the falling edge: write capture, scoreboard pop, CPU halt model.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (bus.BUSY) busy_cycles++;
    if (!bus.nHALT) nhalt_low = 1'b1;
    if (!bus.MMU_nWR && prev_nwr) begin
      chk("wr_expected", 32'(sb_q.size() > 0), 1);
      chk("wr_nrd", bus.MMU_nRD, 1);
      chk("wr_own", bus.OWN, 1);
      chk("wr_doe", bus.MMU_DOE, 1);
      chk("wr_nhalt", bus.nHALT, 0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wr_addr", bus.MMU_ADDR, e.addr);
        chk("wr_data", bus.MMU_DOUT, e.data);
      end
      mem[bus.MMU_ADDR] = bus.MMU_DOUT;
      wr_count++;
    end
    prev_nwr = bus.MMU_nWR;
    if (cpu_auto) begin
      if (!bus.nHALT) begin
        if (halt_cnt >= ack_delay) begin
          bus.BA = 1'b1;
          bus.BS = 1'b1;
        end else begin
          halt_cnt++;
        end
      end else begin
        halt_cnt = 0;
        bus.BA   = 1'b0;
        bus.BS   = 1'b0;
      end
    end
  endtask

  task automatic issue_cmd(input logic [1:0] m, input logic [4:0] s, input logic [4:0] d,
                           input logic [7:0] f);
    bus.CMD_MODE   = m;
    bus.CMD_SRC    = s;
    bus.CMD_DST    = d;
    bus.FILL_VALUE = f;
    bus.START      = 1'b1;
    tick();
    bus.START      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (bus.DONE) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic push_default_fill();
    for (int i = 0; i < 256; i++) sb_q.push_back({8'(i), default_entry(3'(i))});
  endtask

  initial begin
    bit found;
    int wc0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    bus.START = 1'b0; bus.CMD_MODE = 2'b00; bus.CMD_SRC = '0; bus.CMD_DST = '0;
    bus.FILL_VALUE = '0; bus.BA = 1'b0; bus.BS = 1'b0;
    repeat (3) tick();

    chk("rst_nhalt", bus.nHALT, 0);
    chk("rst_busy", bus.BUSY, 1);
    chk("rst_own", bus.OWN, 0);
    chk("rst_doe", bus.MMU_DOE, 0);
    chk("rst_nrd", bus.MMU_nRD, 1);
    chk("rst_nwr", bus.MMU_nWR, 1);
    chk("rst_addr", bus.MMU_ADDR, 0);
    chk("rst_dout", bus.MMU_DOUT, 0);
    chk("rst_done", bus.DONE, 0);

    // Power-up fill: CPU acknowledges 10 cycles after release.
    push_default_fill();
    rst = 1'b0;
    repeat (10) tick();
    chk("init_no_wr_before_ack", wr_count, 0);
    chk("init_own_before_ack", bus.OWN, 0);
    cpu_auto = 1'b1;
    wait_done("init_done", 3000);
    chk("init_ba_at_done", bus.BA, 0);
    chk("init_writes", wr_count, 256);
    chk("init_sb_drained", sb_q.size(), 0);
    chk("init_mem00", mem[8'h00], 8'h80);
    chk("init_mem04", mem[8'h04], 8'h04);
    chk("init_memff", mem[8'hFF], 8'h07);
    chk("init_nhalt", bus.nHALT, 1);
    chk("init_busy", bus.BUSY, 0);

    // Copy task 3 -> task 9 with the CPU acking immediately.
    for (int i = 0; i < 8; i++) mem[8'h18 + i] = 8'h10 + 8'(i);
    for (int i = 0; i < 8; i++) sb_q.push_back({8'h48 + 8'(i), mem[8'h18 + i]});
    ack_delay = 0;
    wr_count = 0;
    busy_cycles = 0;
    issue_cmd(MODE_COPY, 5'd3, 5'd9, 8'h00);
    wait_done("copy_done", 500);
    chk("copy_writes", wr_count, 8);
    chk("copy_sb_drained", sb_q.size(), 0);
    // 1 REQ + 2 sync + 56 entry + 3 REL (ack drop + 2 sync) + 1 FIN
    chk("copy_busy_cycles", busy_cycles, 63);
    for (int i = 0; i < 8; i++) chk("copy_mem", mem[8'h48 + i], 8'h10 + 8'(i));

    // Fill task 31; a START while busy must be ignored.
    ack_delay = 5;
    wr_count = 0;
    for (int i = 0; i < 8; i++) sb_q.push_back({8'hF8 + 8'(i), 8'hC5});
    issue_cmd(MODE_FILL_TASK, 5'd0, 5'd31, 8'hC5);
    repeat (4) tick();
    issue_cmd(MODE_FILL_TASK, 5'd0, 5'd0, 8'h33);
    wait_done("fill_done", 500);
    repeat (20) tick();
    chk("fill_writes", wr_count, 8);
    chk("fill_sb_drained", sb_q.size(), 0);
    chk("fill_memf8", mem[8'hF8], 8'hC5);
    chk("fill_memff", mem[8'hFF], 8'hC5);
    chk("fill_memf7_untouched", mem[8'hF7], 8'h07);
    chk("ignored_start_mem00", mem[8'h00], 8'h80);
    chk("ignored_start_busy", bus.BUSY, 0);

    // Copy task 9 -> task 12, ack withdrawn during entry 4.
    ack_delay = 0;
    wc0 = wr_count;
    for (int i = 0; i < 8; i++) sb_q.push_back({8'h60 + 8'(i), mem[8'h48 + i]});
    issue_cmd(MODE_COPY, 5'd9, 5'd12, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (!bus.MMU_nRD && bus.MMU_ADDR == 8'h4C) found = 1'b1;
    end
    chk("drop_rd4_seen", found, 1);
    cpu_auto = 1'b0;
    bus.BA = 1'b0;
    bus.BS = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (!bus.OWN) found = 1'b1;
    end
    chk("drop_own_fall", found, 1);
    chk("drop_writes_at_release", wr_count - wc0, 5);
    chk("drop_nhalt_held", bus.nHALT, 0);
    repeat (10) tick();
    chk("drop_own_stays", bus.OWN, 0);
    chk("drop_nhalt_stays", bus.nHALT, 0);
    chk("drop_no_writes", wr_count - wc0, 5);
    cpu_auto = 1'b1;
    halt_cnt = 0;
    wait_done("drop_done", 500);
    chk("drop_writes", wr_count - wc0, 8);
    chk("drop_sb_drained", sb_q.size(), 0);
    chk("drop_mem64", mem[8'h64], 8'h14);
    chk("drop_mem67", mem[8'h67], 8'h17);

    // Reserved mode: DONE two cycles after START, no halt.
    nhalt_low = 1'b0;
    issue_cmd(MODE_NOP, 5'd0, 5'd0, 8'h00);
    chk("nop_done_c1", bus.DONE, 0);
    tick();
    chk("nop_done_c2", bus.DONE, 1);
    tick();
    chk("nop_done_c3", bus.DONE, 0);
    chk("nop_nhalt_never_low", nhalt_low, 0);
    chk("nop_busy", bus.BUSY, 0);

    // Reset during the write pulse of a full fill, then a fresh fill.
    push_default_fill();
    issue_cmd(MODE_FILL_ALL, 5'd0, 5'd0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick();
      if (!bus.MMU_nWR && bus.MMU_ADDR == 8'h10) found = 1'b1;
    end
    chk("rstwr_pulse_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("rstwr_nwr_async", bus.MMU_nWR, 1);
    chk("rstwr_own_async", bus.OWN, 0);
    chk("rstwr_busy", bus.BUSY, 1);
    sb_q.delete();
    push_default_fill();
    mem[8'h10] = 8'h5A;
    wr_count = 0;
    tick();
    rst = 1'b0;
    wait_done("rstwr_done", 3000);
    chk("rstwr_writes", wr_count, 256);
    chk("rstwr_sb_drained", sb_q.size(), 0);
    chk("rstwr_mem10", mem[8'h10], 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
